vote_session_ctrl: RTL and testbench

//  Sequences one polling booth in front of the vote logger. Arms a single vote per officer

---
 rtl/vote_pkg.sv | 28 ++
 rtl/vote_tick_counter.sv | 35 +++
 rtl/vote_session_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_vote_session_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared types and constants for the polling booth controller
// Purpose: booth state encoding, one-hot candidate codes, candidate count and
//          the one-hot button check used by the session controller.
// Ports:   none (package).
package vote_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_DEBOUNCE,
        S_LOG,
        S_RELEASE,
        S_RESULT
    } vote_state_t;

    localparam int NUM_CAND = 4;

    localparam logic [3:0] CAND1 = 4'b0001;
    localparam logic [3:0] CAND2 = 4'b0010;
    localparam logic [3:0] CAND3 = 4'b0100;
    localparam logic [3:0] CAND4 = 4'b1000;

    // A press is a valid choice only when exactly one candidate button is down.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v == CAND1) || (v == CAND2) || (v == CAND3) || (v == CAND4);
    endfunction

endpackage

// File: rtl/vote_tick_counter.sv
// rtl/vote_tick_counter.sv - clearable cycle counter with terminal-count flag
// Purpose: counts enabled cycles 0..MAX-1 and wraps; tc is high while the count
//          sits at MAX-1, so an enabled cycle with tc set is the MAX-th one.
// Ports:   clk    in  system clock
//          rst    in  asynchronous active-high reset
//          clear  in  synchronous clear to 0 (wins over enable)
//          enable in  advance the count this cycle
//          tc     out count == MAX-1
module vote_tick_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

    logic [W-1:0] cnt;

    assign tc = (cnt == W'(MAX - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vote_session_ctrl.sv
// rtl/vote_session_ctrl.sv - polling booth session sequencer in front of the vote logger
// Purpose: arms one vote per officer arm edge, debounces the one-hot candidate
//          button, strobes vote_logged/candidate for one cycle, and rotates the
//          result display while the poll is closed.
// Optional feature: define VOTE_TIMEOUT_EN to disarm a voter who takes longer
//          than TIMEOUT_CYCLES armed cycles (timeout pulse, back to IDLE).
// Ports:   clk           in   system clock
//          reset_all     in   asynchronous active-high reset
//          arm           in   officer enable level, rising edge arms one vote
//          close_poll    in   1 = poll closed / results
//          button[3:0]   in   voter buttons, one-hot = valid choice
//          vote_logged   out  one-cycle strobe to logger
//          candidate[3:0]out  one-hot choice while vote_logged, else 0
//          mode          out  1 while showing results
//          ready         out  booth armed, awaiting a choice
//          invalid_press out  one-cycle pulse on a multi-hot press
//          timeout       out  one-cycle pulse when the armed window expires
//          result_sel[1:0]out candidate index shown in results
//          votes_cast[7:0]out votes issued since reset, saturating
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = 4,
    parameter int unsigned DISP_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset_all,
    input  logic       arm,
    input  logic       close_poll,
    input  logic [3:0] button,
    output logic       vote_logged,
    output logic [3:0] candidate,
    output logic       mode,
    output logic       ready,
    output logic       invalid_press,
    output logic       timeout,
    output logic [1:0] result_sel,
    output logic [7:0] votes_cast
);

    vote_state_t state, state_n;
    logic [3:0]  cap, cap_n;
    logic        arm_q;
    logic        inv_n, to_n;
    logic        deb_tc, disp_tc;
    logic        armed, btn_match, to_fire;

    assign armed     = (state == S_READY) || (state == S_DEBOUNCE);
    assign btn_match = (button == cap);

    // Zero-length windows are meaningless; such a build leaves this marker
    // block in the hierarchy.
    if (DEB_CYCLES < 1 || DISP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param_cfg
    end

    // Held at zero outside DEBOUNCE so each new capture starts from a fresh count.
    vote_tick_counter #(.MAX(DEB_CYCLES)) u_deb_cnt (
        .clk    (clk),
        .rst    (reset_all),
        .clear  (state != S_DEBOUNCE),
        .enable ((state == S_DEBOUNCE) && btn_match),
        .tc     (deb_tc)
    );

    vote_tick_counter #(.MAX(DISP_CYCLES)) u_disp_cnt (
        .clk    (clk),
        .rst    (reset_all),
        .clear  (state != S_RESULT),
        .enable (state == S_RESULT),
        .tc     (disp_tc)
    );

`ifdef VOTE_TIMEOUT_EN
    logic to_tc;

    // Counts every armed cycle from the first READY cycle; bouncing between
    // READY and DEBOUNCE does not restart the window.
    vote_tick_counter #(.MAX(TIMEOUT_CYCLES)) u_to_cnt (
        .clk    (clk),
        .rst    (reset_all),
        .clear  (!armed),
        .enable (armed),
        .tc     (to_tc)
    );

    assign to_fire = armed && to_tc;
`else
    assign to_fire = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cap_n   = cap;
        inv_n   = 1'b0;
        to_n    = 1'b0;
        // Closing the poll preempts everything except a strobe already in flight.
        if (close_poll && (state != S_LOG) && (state != S_RESULT)) begin
            state_n = S_RESULT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm && !arm_q) begin
                        state_n = S_READY;
                    end
                end
                S_READY: begin
                    if (is_onehot4(button)) begin
                        cap_n   = button;
                        state_n = S_DEBOUNCE;
                    end else if (button != 4'b0000) begin
                        inv_n = 1'b1;
                    end
                end
                S_DEBOUNCE: begin
                    if (!btn_match) begin
                        state_n = S_READY;
                    end else if (deb_tc) begin
                        state_n = S_LOG;
                    end
                end
                S_LOG: begin
                    state_n = close_poll ? S_RESULT : S_RELEASE;
                end
                S_RELEASE: begin
                    if (button == 4'b0000) begin
                        state_n = S_IDLE;
                    end
                end
                S_RESULT: begin
                    if (!close_poll) begin
                        state_n = S_IDLE;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
            // A vote completing on the expiry cycle still goes through.
            if (to_fire && (state_n != S_LOG)) begin
                state_n = S_IDLE;
                inv_n   = 1'b0;
                to_n    = 1'b1;
            end
        end
    end

    // Outputs are loaded from the next state so they line up with the state
    // they describe and come straight from flops.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            state         <= S_IDLE;
            cap           <= 4'b0000;
            arm_q         <= 1'b0;
            vote_logged   <= 1'b0;
            candidate     <= 4'b0000;
            mode          <= 1'b0;
            ready         <= 1'b0;
            invalid_press <= 1'b0;
            timeout       <= 1'b0;
            result_sel    <= 2'd0;
            votes_cast    <= 8'd0;
        end else begin
            state         <= state_n;
            cap           <= cap_n;
            arm_q         <= arm;
            vote_logged   <= (state_n == S_LOG);
            candidate     <= (state_n == S_LOG) ? cap_n : 4'b0000;
            mode          <= (state_n == S_RESULT);
            ready         <= (state_n == S_READY) || (state_n == S_DEBOUNCE);
            invalid_press <= inv_n;
            timeout       <= to_n;
            if (state_n != S_RESULT) begin
                result_sel <= 2'd0;
            end else if ((state == S_RESULT) && disp_tc) begin
                result_sel <= (result_sel == 2'(NUM_CAND - 1)) ? 2'd0 : result_sel + 2'd1;
            end
            if ((state_n == S_LOG) && (votes_cast != 8'hFF)) begin
                votes_cast <= votes_cast + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb/tb_vote_session_ctrl.sv - randomized scoreboard bench for vote_session_ctrl
module tb_vote_session_ctrl;
    import vote_pkg::*;

    localparam int DEB  = 4;
    localparam int DISP = 8;
    localparam int TO   = 20;

    typedef struct {
        logic [3:0] cand;
        int         cyc;
        int         cnt;
    } exp_vote_t;

    logic       clk, reset_all, arm, close_poll;
    logic [3:0] button;
    logic       vote_logged, mode, ready, invalid_press, timeout;
    logic [3:0] candidate;
    logic [1:0] result_sel;
    logic [7:0] votes_cast;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int model_cnt = 0;
    bit prev_vl = 0;
    exp_vote_t exp_q[$];
    int        inv_q[$];
    logic [3:0] cands[4];

    vote_session_ctrl #(
        .DEB_CYCLES     (DEB),
        .DISP_CYCLES    (DISP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset_all     (reset_all),
        .arm           (arm),
        .close_poll    (close_poll),
        .button        (button),
        .vote_logged   (vote_logged),
        .candidate     (candidate),
        .mode          (mode),
        .ready         (ready),
        .invalid_press (invalid_press),
        .timeout       (timeout),
        .result_sel    (result_sel),
        .votes_cast    (votes_cast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every strobe or invalid pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (!reset_all) begin
            if (vote_logged) begin
                chk("no_back_to_back_strobe", prev_vl, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_vote", 1, 0);
                end else begin
                    exp_vote_t e;
                    e = exp_q.pop_front();
                    chk("vote_candidate", candidate, e.cand);
                    chk("vote_cycle", cyc, e.cyc);
                    chk("vote_count", votes_cast, e.cnt);
                end
            end
            if (invalid_press) begin
                if (inv_q.size() == 0) begin
                    chk("unexpected_invalid", 1, 0);
                end else begin
                    chk("invalid_cycle", cyc, inv_q.pop_front());
                end
            end
            prev_vl = vote_logged;
        end
    end

    function automatic int next_cnt(input int c);
        return (c < 255) ? c + 1 : 255;
    endfunction

    // One armed session from IDLE: optional invalid press, optional bounce,
    // a stable press of h cycles, optional arm toggling while still held.
    task automatic do_vote(input logic [3:0] cand, input int h, input bit invalid,
                           input bit bounce, input bit lockout);
        exp_vote_t e;
        logic [3:0] b;
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        chk("ready_after_arm", ready, 1);
        if (invalid) begin
            do b = 4'($urandom_range(0, 15)); while ($countones(b) < 2);
            button = b;
            inv_q.push_back(cyc + 1);
            tick(1);
            button = 4'b0000;
            chk("ready_after_invalid", ready, 1);
            tick(1);
        end
        if (bounce) begin
            button = cand;
            tick($urandom_range(1, DEB));
            button = 4'b0000;
            tick($urandom_range(1, 2));
            chk("ready_after_bounce", ready, 1);
        end
        button    = cand;
        model_cnt = next_cnt(model_cnt);
        e.cand = cand;
        e.cyc  = cyc + DEB + 1;
        e.cnt  = model_cnt;
        exp_q.push_back(e);
        tick(h);
        if (lockout) begin
            repeat (4) begin
                arm = ~arm;
                tick(1);
            end
            arm = 1'b0;
            tick(1);
        end
        button = 4'b0000;
        tick(3);
        chk("idle_after_release", ready, 0);
    endtask

    initial begin
        cands[0] = CAND1; cands[1] = CAND2; cands[2] = CAND3; cands[3] = CAND4;
        reset_all = 1'b1; arm = 1'b0; close_poll = 1'b0; button = 4'b0000;
        tick(2);
        chk("rst_vote_logged", vote_logged, 0);
        chk("rst_candidate", candidate, 0);
        chk("rst_mode", mode, 0);
        chk("rst_ready", ready, 0);
        chk("rst_result_sel", result_sel, 0);
        chk("rst_votes_cast", votes_cast, 0);
        reset_all = 1'b0;
        tick(2);

        // Candidate 3 held six cycles: one vote.
        do_vote(CAND3, 6, 1'b0, 1'b0, 1'b0);
        chk("votes_after_first", votes_cast, 1);
        // Invalid press then vote; bounce then stable CAND1; lockout.
        do_vote(CAND2, DEB + 1, 1'b1, 1'b0, 1'b0);
        do_vote(CAND1, DEB + 2, 1'b0, 1'b1, 1'b0);
        do_vote(CAND4, DEB + 1, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            do_vote(cands[$urandom_range(0, 3)], $urandom_range(DEB + 1, DEB + 2),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end
        chk("votes_after_random", votes_cast, model_cnt);

        // Result rotation; arm and button ignored meanwhile.
        close_poll = 1'b1;
        for (int j = 0; j <= 33; j++) begin
            tick(1);
            if (j == 3) begin arm = 1'b1; button = CAND2; end
            if (j == 12) begin arm = 1'b0; button = 4'b0000; end
            if (j == 0 || j == 7 || j == 8 || j == 16 || j == 24 || j == 31 || j == 32) begin
                chk("result_sel", result_sel, (j / DISP) % 4);
                chk("result_mode", mode, 1);
            end
        end
        close_poll = 1'b0;
        tick(1);
        chk("open_mode", mode, 0);
        chk("open_result_sel", result_sel, 0);
        tick(2);

        // Closing the poll during the strobe cycle keeps that vote.
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        begin
            exp_vote_t e;
            button    = CAND2;
            model_cnt = next_cnt(model_cnt);
            e.cand = CAND2; e.cyc = cyc + DEB + 1; e.cnt = model_cnt;
            exp_q.push_back(e);
        end
        tick(DEB + 1);
        close_poll = 1'b1;
        tick(1);
        chk("close_in_log_mode", mode, 1);
        button = 4'b0000;
        tick(2);
        close_poll = 1'b0;
        tick(3);

        // Reset in the middle of a debounce: no vote, counter cleared.
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        button = CAND4;
        tick(2);
        reset_all = 1'b1;
        tick(1);
        chk("midrst_vote_logged", vote_logged, 0);
        chk("midrst_candidate", candidate, 0);
        chk("midrst_ready", ready, 0);
        chk("midrst_mode", mode, 0);
        chk("midrst_votes_cast", votes_cast, 0);
        model_cnt = 0;
        button = 4'b0000;
        reset_all = 1'b0;
        tick(2);
        do_vote(CAND1, DEB + 1, 1'b0, 1'b0, 1'b0);
        chk("votes_after_midrst", votes_cast, 1);

        // Armed with no press.
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
`ifdef VOTE_TIMEOUT_EN
        tick(TO - 1);
        chk("timeout_before", timeout, 0);
        chk("ready_before_timeout", ready, 1);
        tick(1);
        chk("timeout_pulse", timeout, 1);
        chk("ready_at_timeout", ready, 0);
        tick(1);
        chk("timeout_one_cycle", timeout, 0);
`else
        tick(TO + 5);
        chk("no_timeout", timeout, 0);
        chk("still_ready", ready, 1);
        close_poll = 1'b1;
        tick(2);
        close_poll = 1'b0;
        tick(2);
`endif
        tick(5);
        chk("pending_votes", exp_q.size(), 0);
        chk("pending_invalid", inv_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
